stream_demux_1n: RTL and testbench
==================================

Name: stream_demux_1n

Overview:
- Parametrised successor to the combinational 1:8 demux. Routes a single valid/ready input stream to one of N_CH output channels, chosen by a per-beat select.
- Each channel has a one-entry output register, so outputs are registered with 1-cycle latency and channels stall independently.
- Sits between a shared producer (e.g. lab datapath or UART RX) and per-consumer logic.

Parameters:
- DATA_W, 8, width of the data beat.
- N_CH, 8, number of output channels (2..64; need not be a power of 2).
- SEL_W, $clog2(N_CH), select width; derived, not overridden.
- CNT_W, 16, width of the dropped-beat counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DATA_W  input beat.
- in_sel  in  SEL_W  destination channel for the beat.
- out_valid  out  N_CH  per-channel valid.
- out_ready  in  N_CH  per-channel ready.
- out_data  out  N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- drop_cnt  out  CNT_W  count of beats dropped for out-of-range select.

Behaviour:
- Reset (async assert, sync release): out_valid = 0, out_data = 0, drop_cnt = 0, all packet state idle.
- Channel buffer c is free when out_valid[c] = 0 or out_ready[c] = 1 (same-cycle drain allowed, full throughput).
- in_ready is combinational:
  - in_sel < N_CH: in_ready = free(in_sel).
  - in_sel >= N_CH: in_ready = 1.
- Accepted beat with in_sel < N_CH: on the next edge, out_data[in_sel] <= in_data and out_valid[in_sel] <= 1. Latency is 1 cycle.
- Channel c with out_valid & out_ready and no new beat for c: out_valid[c] <= 0. out_data[c] holds its last value.
- Simultaneous drain and refill on the same channel: the new beat replaces the old one, out_valid stays 1, no bubble.
- Non-selected channels are unaffected by input activity.
- Out-of-range select (in_sel >= N_CH): the beat is consumed and discarded, no out_valid is set, and drop_cnt increments. drop_cnt saturates at 2^CNT_W-1.
- Output stability: while out_valid[c] = 1 and out_ready[c] = 0, out_data[c] must be stable.
- in_ready never depends on out_ready of a non-selected channel.
- Reset mid-transfer: all buffered beats are lost. in_ready is still driven combinationally during reset, but no beat is accepted while rst = 1.

Optional Feature:
- Macro: STREAM_DEMUX_PKT_EN.
- Defined:
  - Adds input port in_last (1 bit) and output port out_last (N_CH bits), buffered with the data.
  - Routing is locked per packet. in_sel is sampled on the first beat of a packet and ignored until the beat with in_last = 1 is accepted.
  - Single-beat packets (first beat has in_last = 1) lock and unlock in the same transfer.
  - A dropped packet (out-of-range select) discards all of its beats but increments drop_cnt once per packet.
  - Reset clears the lock.
- Undefined: every beat is routed independently by its own in_sel, and the ports in_last and out_last are absent.

Decomposition:
- Package stream_demux_pkg holds:
  - the function clog2_min1, returning at least 1 for N_CH = 1 guards;
  - the localparam SEL_W helper;
  - the typedef pkt_state_t {PKT_IDLE, PKT_LOCKED, PKT_DROP} used under STREAM_DEMUX_PKT_EN.
- One natural sub-module, stream_demux_slot: a one-entry valid/ready register with load, drain, free and data outputs (plus last under the macro). It is instantiated N_CH times in a generate loop.
- Top level holds select decode, the in_ready mux, the drop counter and the packet FSM.

Test Plan:
- Reset, then sweep in_sel 0..7 with in_data = 8'hA0+sel and all out_ready = 1. Each out_valid[sel] pulses exactly 1 cycle after acceptance with the matching data, and in_ready stays 1 throughout.
- Hold out_ready[3] = 0 and send two beats to ch3 (8'h11, 8'h22). The first is buffered; in_ready drops for the second until out_ready[3] rises. ch3 then presents 8'h11 followed by 8'h22, and a beat to ch5 in between passes unblocked.
- Back-to-back beats to ch2 with out_ready[2] = 1 every cycle: one beat per cycle, out_valid[2] stays high continuously, no bubbles.
- N_CH = 5: send beats with in_sel = 5, 6, 7. in_ready = 1, no out_valid asserts, drop_cnt = 3. Force drop_cnt near its maximum and confirm it saturates at 16'hFFFF.
- Assert rst for 1 cycle while ch1 and ch6 hold valid beats. Asynchronously out_valid = 0, out_data = 0, drop_cnt = 0, and normal operation resumes on the next edge.
- With STREAM_DEMUX_PKT_EN, send a 3-beat packet with in_sel = 4 on beat 1 and in_sel = 0, 7 on beats 2–3. All 3 beats appear on ch4, with out_last[4] set only on beat 3, and the next packet routes by its own first-beat select.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared helpers for the 1:N stream demultiplexer.
//   clog2_min1   : select-width helper, never returns less than 1 so that a
//                  degenerate single-channel build still has a legal port.
//   DEFAULT_N_CH : default channel count of the demux.
//   pkt_state_t  : packet routing lock state, used only when the design is
//                  built with STREAM_DEMUX_PKT_EN.
// -----------------------------------------------------------------------------
package stream_demux_pkg;

  localparam int DEFAULT_N_CH = 8;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    PKT_IDLE,
    PKT_LOCKED,
    PKT_DROP
  } pkt_state_t;

endpackage

// File: rtl/stream_demux_slot.sv
// -----------------------------------------------------------------------------
// stream_demux_slot
// One-entry valid/ready output register for a single demux channel.
// The slot is free when empty or when its consumer drains it this cycle, so a
// drain and a refill can happen on the same edge without a bubble.
// Optional macro: STREAM_DEMUX_PKT_EN adds a last flag stored with the data.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   load         write load_data into the slot on the next edge
//   load_data    beat to store
//   load_last    end-of-packet flag to store (STREAM_DEMUX_PKT_EN only)
//   drain        consumer ready for this channel
//   valid        slot holds a beat
//   data         stored beat (holds its last value after draining)
//   last         stored end-of-packet flag (STREAM_DEMUX_PKT_EN only)
//   free         slot can accept a beat this cycle
// -----------------------------------------------------------------------------
module stream_demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
`ifdef STREAM_DEMUX_PKT_EN
  input  logic              load_last,
  output logic              last,
`endif
  input  logic              drain,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  assign free = ~valid | drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      // load is only asserted while free, so this also covers drain+refill
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

`ifdef STREAM_DEMUX_PKT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b0;
    end else if (load) begin
      last <= load_last;
    end
  end
`endif

endmodule

// File: rtl/stream_demux_1n.sv
// -----------------------------------------------------------------------------
// stream_demux_1n
// Routes one valid/ready input stream to one of N_CH registered output
// channels, chosen per beat by in_sel. Each channel has a one-entry slot so
// channels stall independently and outputs appear one cycle after acceptance.
// Beats whose select is out of range are consumed, discarded and counted in a
// saturating drop counter.
// Optional macro: STREAM_DEMUX_PKT_EN adds in_last/out_last and locks routing
// for the duration of a packet (select sampled on the first beat only).
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   in_valid    input beat valid
//   in_ready    input beat accepted when in_valid & in_ready (combinational)
//   in_data     input beat
//   in_sel      destination channel
//   in_last     end of packet (STREAM_DEMUX_PKT_EN only)
//   out_valid   per-channel valid
//   out_ready   per-channel ready
//   out_data    channel c at [c*DATA_W +: DATA_W]
//   out_last    per-channel end of packet (STREAM_DEMUX_PKT_EN only)
//   drop_cnt    saturating count of dropped beats / packets
//
// Packet FSM (STREAM_DEMUX_PKT_EN only):
//   state      | meaning
//   PKT_IDLE   | next accepted beat starts a packet and samples in_sel
//   PKT_LOCKED | mid-packet, beats follow lock_sel until in_last is accepted
//   PKT_DROP   | mid-packet with out-of-range select, beats are discarded
// -----------------------------------------------------------------------------
module stream_demux_1n
  import stream_demux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_CH   = DEFAULT_N_CH,
  parameter  int CNT_W  = 16,
  localparam int SEL_W  = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
`ifdef STREAM_DEMUX_PKT_EN
  input  logic                   in_last,
  output logic [N_CH-1:0]        out_last,
`endif
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]       drop_cnt
);

  // One extra bit so N_CH itself is representable for the range compare.
  localparam logic [SEL_W:0] N_CH_V = (SEL_W+1)'(N_CH);

  logic [N_CH-1:0]  slot_free;
  logic [N_CH-1:0]  sel_hit;
  logic [N_CH-1:0]  slot_load;
  logic [SEL_W-1:0] route_sel;
  logic             route_drop;
  logic             fire;
  logic             drop_inc;

`ifdef STREAM_DEMUX_PKT_EN
  pkt_state_t       pkt_state;
  logic [SEL_W-1:0] lock_sel;

  always_comb begin
    route_sel  = (pkt_state == PKT_LOCKED) ? lock_sel : in_sel;
    route_drop = (pkt_state == PKT_DROP) || ({1'b0, route_sel} >= N_CH_V);
  end

  // A dropped packet counts once, on its first beat.
  assign drop_inc = fire & route_drop & (pkt_state == PKT_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_state <= PKT_IDLE;
      lock_sel  <= '0;
    end else if (fire) begin
      case (pkt_state)
        PKT_IDLE: begin
          // Single-beat packets lock and unlock in the same transfer.
          if (!in_last) begin
            pkt_state <= route_drop ? PKT_DROP : PKT_LOCKED;
            lock_sel  <= in_sel;
          end
        end
        default: begin
          if (in_last) pkt_state <= PKT_IDLE;
        end
      endcase
    end
  end
`else
  assign route_sel  = in_sel;
  assign route_drop = ({1'b0, route_sel} >= N_CH_V);
  assign drop_inc   = fire & route_drop;
`endif

  // One-hot decode of the routed channel; an out-of-range select hits nothing,
  // which keeps the ready mux free of out-of-bounds indexing.
  always_comb begin
    sel_hit = '0;
    for (int c = 0; c < N_CH; c++) begin
      sel_hit[c] = (route_sel == SEL_W'(c));
    end
  end

  // Only the selected channel's free flag reaches in_ready.
  assign in_ready  = route_drop | (|(slot_free & sel_hit));
  assign fire      = in_valid & in_ready & ~rst;
  assign slot_load = {N_CH{fire & ~route_drop}} & sel_hit;

  for (genvar c = 0; c < N_CH; c++) begin : g_slot
    stream_demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[c]),
      .load_data (in_data),
`ifdef STREAM_DEMUX_PKT_EN
      .load_last (in_last),
      .last      (out_last[c]),
`endif
      .drain     (out_ready[c]),
      .valid     (out_valid[c]),
      .data      (out_data[c*DATA_W +: DATA_W]),
      .free      (slot_free[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_inc && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux_1n.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1n
// Two demux instances share one stimulus stream: dut8 (N_CH = 8, every select
// in range) and dut5 (N_CH = 5, selects 5..7 are dropped). A channel-level
// model tracks each instance and is compared on every falling edge; directed
// literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_stream_demux_1n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       = 1'b1;
  logic        in_valid  = 1'b0;
  logic [7:0]  in_data   = 8'h00;
  logic [2:0]  in_sel    = 3'd0;
  logic [7:0]  out_ready = 8'h00;

  logic        ready8, ready5;
  logic [7:0]  ov8;
  logic [4:0]  ov5;
  logic [63:0] od8;
  logic [39:0] od5;
  logic [15:0] dc8, dc5;
`ifdef STREAM_DEMUX_PKT_EN
  logic        in_last = 1'b1;
  logic [7:0]  ol8;
  logic [4:0]  ol5;
`endif

  stream_demux_1n #(.DATA_W(8), .N_CH(8), .CNT_W(16)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (ready8),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef STREAM_DEMUX_PKT_EN
    .in_last   (in_last),
    .out_last  (ol8),
`endif
    .out_valid (ov8),
    .out_ready (out_ready),
    .out_data  (od8),
    .drop_cnt  (dc8)
  );

  stream_demux_1n #(.DATA_W(8), .N_CH(5), .CNT_W(16)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (ready5),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef STREAM_DEMUX_PKT_EN
    .in_last   (in_last),
    .out_last  (ol5),
`endif
    .out_valid (ov5),
    .out_ready (out_ready[4:0]),
    .out_data  (od5),
    .drop_cnt  (dc5)
  );

  int checks   = 0;
  int failures = 0;

  // Model: per instance, which channels hold a beat, what they show, the drop
  // count, and the packet lock (0 idle, 1 locked to mlock, 2 dropping).
  bit   [7:0] mval  [2];
  logic [7:0] mdat  [2][8];
  bit   [7:0] mlast [2];
  int         mdrop [2];
  int         mstate[2];
  int         mlock [2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nch(input int k);
    return (k == 0) ? 8 : 5;
  endfunction

  function automatic bit cur_last();
`ifdef STREAM_DEMUX_PKT_EN
    return in_last;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int route(input int k);
    if (mstate[k] == 1) return mlock[k];
    return int'(in_sel);
  endfunction

  function automatic bit routed_drop(input int k);
    return (mstate[k] == 2) || (route(k) >= nch(k));
  endfunction

  function automatic bit exp_ready(input int k);
    if (routed_drop(k)) return 1'b1;
    return !mval[k][route(k)] || out_ready[route(k)];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mval[k]   = '0;
      mlast[k]  = '0;
      mdrop[k]  = 0;
      mstate[k] = 0;
      mlock[k]  = 0;
      for (int c = 0; c < 8; c++) mdat[k][c] = 8'h00;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit fire;
      bit drop;
      int s;
      fire = in_valid && exp_ready(k);
      drop = routed_drop(k);
      s    = route(k);
      for (int c = 0; c < nch(k); c++)
        if (mval[k][c] && out_ready[c]) mval[k][c] = 1'b0;
      if (fire && !drop) begin
        mval[k][s]  = 1'b1;
        mdat[k][s]  = in_data;
        mlast[k][s] = cur_last();
      end
      if (fire && drop && mstate[k] == 0 && mdrop[k] < 65535) mdrop[k]++;
`ifdef STREAM_DEMUX_PKT_EN
      if (fire) begin
        if (mstate[k] == 0 && !cur_last()) begin
          mstate[k] = drop ? 2 : 1;
          mlock[k]  = s;
        end else if (mstate[k] != 0 && cur_last()) begin
          mstate[k] = 0;
        end
      end
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    #1;
  endtask

  task automatic beat(input logic [2:0] sel, input logic [7:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        logic [63:0] ev, ed;
        ev = '0;
        ed = '0;
        for (int c = 0; c < nch(k); c++) begin
          ev[c]         = mval[k][c];
          ed[c*8 +: 8]  = mdat[k][c];
        end
        if (k == 0) begin
          check("ready8", ready8, exp_ready(0));
          check("valid8", ov8, ev);
          check("data8", od8, ed);
          check("drop8", dc8, mdrop[0]);
`ifdef STREAM_DEMUX_PKT_EN
          check("last8", ol8 & ov8, mlast[0] & mval[0]);
`endif
        end else begin
          check("ready5", ready5, exp_ready(1));
          check("valid5", ov5, ev);
          check("data5", od5, ed);
          check("drop5", dc5, mdrop[1]);
`ifdef STREAM_DEMUX_PKT_EN
          check("last5", ol5 & ov5, mlast[1][4:0] & mval[1][4:0]);
`endif
        end
      end
    end
  end

  initial begin
    model_reset();
    step();
    step();
    check("rst_valid8", ov8, 0);
    check("rst_data8", od8, 0);
    check("rst_drop5", dc5, 0);
    rst = 1'b0;
    step();

    // Sweep every select with all consumers ready.
    out_ready = 8'hFF;
    for (int s = 0; s < 8; s++) begin
      beat(3'(s), 8'hA0 + 8'(s));
      #1;
      check("sweep_ready", ready8, 1);
      step();
      check("sweep_valid", ov8, 64'(1) << s);
      check("sweep_data", od8[s*8 +: 8], 8'hA0 + 8'(s));
    end
    in_valid = 1'b0;
    step();
    check("sweep_drain", ov8, 0);
    check("sweep_drop5", dc5, 3);
    check("sweep_nodrop8", dc8, 0);

    // Stall ch3; ch5 passes while ch3 is blocked.
    out_ready = 8'hF7;
    beat(3'd3, 8'h11);
    #1;
    check("stall_ready1", ready8, 1);
    step();
    beat(3'd3, 8'h22);
    #1;
    check("stall_ready2", ready8, 0);
    step();
    check("stall_hold", od8[24 +: 8], 8'h11);
    beat(3'd5, 8'h55);
    #1;
    check("stall_ch5_ready", ready8, 1);
    step();
    check("stall_ch5_valid", ov8, 8'h28);
    check("stall_ch5_data", od8[40 +: 8], 8'h55);
    out_ready = 8'hFF;
    beat(3'd3, 8'h22);
    #1;
    check("stall_release", ready8, 1);
    step();
    check("stall_refill", ov8, 8'h08);
    check("stall_second", od8[24 +: 8], 8'h22);
    in_valid = 1'b0;
    step();

    // Back-to-back on ch2: no bubbles.
    for (int i = 0; i < 6; i++) begin
      beat(3'd2, 8'h60 + 8'(i));
      step();
      check("b2b_valid", ov8, 8'h04);
      check("b2b_data", od8[16 +: 8], 8'h60 + 8'(i));
    end
    in_valid = 1'b0;
    step();

    // Saturate dut5's drop counter (already at 4).
    beat(3'd7, 8'h77);
    repeat (65540) step();
    check("sat_drop5", dc5, 16'hFFFF);
    check("sat_drop8", dc8, 0);
    step();
    check("sat_hold", dc5, 16'hFFFF);
    in_valid = 1'b0;
    step();

    // Reset while ch1 and ch6 hold beats.
    out_ready = 8'h00;
    beat(3'd1, 8'h91);
    step();
    beat(3'd6, 8'h96);
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", ov8, 8'h42);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_valid8", ov8, 0);
    check("arst_valid5", ov5, 0);
    check("arst_data8", od8, 0);
    check("arst_drop8", dc8, 0);
    check("arst_drop5", dc5, 0);
    step();
    rst = 1'b0;
    out_ready = 8'hFF;
    beat(3'd1, 8'h5A);
    step();
    check("resume_valid", ov8, 8'h02);
    check("resume_data", od8[8 +: 8], 8'h5A);
    in_valid = 1'b0;
    step();

`ifdef STREAM_DEMUX_PKT_EN
    // 3-beat packet locked to ch4, then a packet routed by its own select.
    in_last = 1'b0;
    beat(3'd4, 8'hC1);
    step();
    check("pkt_b1", ov8, 8'h10);
    check("pkt_b1_last", ol8[4], 0);
    beat(3'd0, 8'hC2);
    step();
    check("pkt_b2", ov8, 8'h10);
    check("pkt_b2_data", od8[32 +: 8], 8'hC2);
    in_last = 1'b1;
    beat(3'd7, 8'hC3);
    step();
    check("pkt_b3", ov8, 8'h10);
    check("pkt_b3_data", od8[32 +: 8], 8'hC3);
    check("pkt_b3_last", ol8, 8'h10);
    beat(3'd2, 8'hC4);
    step();
    check("pkt_next", ov8, 8'h04);
    check("pkt_next_last", ol8[2], 1);
    // Packet with select 6: dropped by dut5, counted once.
    in_last = 1'b0;
    beat(3'd6, 8'hD1);
    step();
    beat(3'd1, 8'hD2);
    step();
    check("pktdrop_novalid5", ov5, 0);
    in_last = 1'b1;
    beat(3'd1, 8'hD3);
    step();
    check("pktdrop_ch6", od8[48 +: 8], 8'hD3);
    check("pktdrop_cnt5", dc5, 1);
    in_valid = 1'b0;
    step();
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
